// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and its receiver
// successor.
//   PAR_*        parity mode codes carried on the 2-bit parity-mode field
//   uart_state_e frame FSM state encoding
//   baud_rate    baud_select code -> line rate in baud
//   baud_div     16x-oversample tick divisor, round(clk_freq / (16 * baud))
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;
    localparam logic [1:0] PAR_MARK = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP1  = 3'd4,
        ST_STOP2  = 3'd5
    } uart_state_e;

    function automatic int baud_rate(input logic [2:0] sel);
        case (sel)
            3'd0:    return 300;
            3'd1:    return 1200;
            3'd2:    return 4800;
            3'd3:    return 9600;
            3'd4:    return 19200;
            3'd5:    return 38400;
            3'd6:    return 57600;
            default: return 115200;
        endcase
    endfunction

    // Adding half the denominator before dividing rounds to nearest.
    function automatic int baud_div(input int clk_freq, input logic [2:0] sel);
        int rate;
        rate = baud_rate(sel);
        return (clk_freq + 8 * rate) / (16 * rate);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO with first-word-fall-through read.
//   clk, rst   clock, asynchronous active-high reset (clears pointers)
//   push       write wr_data at the edge; ignored while full
//   pop        advance the head at the edge; ignored while empty
//   rd_data    current head word, read directly from the storage flops
//   full       level == DEPTH
//   empty      level == 0
//   level      current occupancy, 0..DEPTH
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    // One extra pointer bit distinguishes full from empty.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign level   = wr_ptr - rd_ptr;
    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: nothing is readable until a push lands.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter with runtime parity and stop-bit
// selection; queued frames are sent back to back with no idle gap.
//   clk, reset   system clock, asynchronous active-high reset
//   Tx_EN        allows a new frame to start; a running frame always completes
//   Tx_WR        write strobe for Tx_DATA
//   Tx_DATA      word to queue
//   baud_select  line rate code (see uart_pkg::baud_rate)
//   Tx_PARITY    parity mode (PAR_NONE/EVEN/ODD/MARK)
//   Tx_STOP2     0 = one stop bit, 1 = two stop bits
//   TxD          registered serial line, idles high
//   Tx_BUSY      FIFO non-empty or a frame in progress
//   Tx_FULL      FIFO full
//   Tx_EMPTY     FIFO empty
//   Tx_LEVEL     FIFO occupancy
//   Tx_OVERFLOW  one-cycle pulse after a write was dropped
//   fsm_state    frame FSM state, for observation
//
// Write handshake: Tx_WR is a one-cycle strobe and !Tx_FULL is its ready. A
// word is taken at the rising edge where Tx_WR=1 and Tx_FULL=0. Tx_WR=1 with
// Tx_FULL=1 drops the word (even if a pop happens at that same edge) and
// raises Tx_OVERFLOW for the following cycle.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          Tx_EN,
    input  logic                          Tx_WR,
    input  logic [DATA_W-1:0]             Tx_DATA,
    input  logic [2:0]                    baud_select,
    input  logic [1:0]                    Tx_PARITY,
    input  logic                          Tx_STOP2,
    output logic                          TxD,
    output logic                          Tx_BUSY,
    output logic                          Tx_FULL,
    output logic                          Tx_EMPTY,
    output logic [$clog2(FIFO_DEPTH):0]   Tx_LEVEL,
    output logic                          Tx_OVERFLOW,
    output uart_state_e                   fsm_state
);

    localparam int DIV_TAB [8] = '{
        baud_div(CLK_FREQ, 3'd0), baud_div(CLK_FREQ, 3'd1),
        baud_div(CLK_FREQ, 3'd2), baud_div(CLK_FREQ, 3'd3),
        baud_div(CLK_FREQ, 3'd4), baud_div(CLK_FREQ, 3'd5),
        baud_div(CLK_FREQ, 3'd6), baud_div(CLK_FREQ, 3'd7)
    };
    // The slowest rate has the largest divisor and sets the counter width.
    localparam int DIV_W = $clog2(DIV_TAB[0]);
    localparam int BIT_W = $clog2(DATA_W);

    uart_state_e       state;
    uart_state_e       state_nxt;
    logic [DATA_W-1:0] head;
    logic [DATA_W-1:0] shreg;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic [DIV_W-1:0]  div_cnt;
    logic [DIV_W-1:0]  div_last;
    logic [3:0]        os_cnt;
    logic [BIT_W-1:0]  bit_idx;
    logic [1:0]        par_mode;
    logic              stop2;
    logic              par_bit;
    logic              par_calc;
    logic              bit_done;
    logic              frame_end;
    logic              txd_nxt;

    uart_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .push    (Tx_WR),
        .pop     (pop),
        .wr_data (Tx_DATA),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (Tx_LEVEL)
    );

    assign Tx_FULL   = fifo_full;
    assign Tx_EMPTY  = fifo_empty;
    assign Tx_BUSY   = (state != ST_IDLE) || !fifo_empty;
    assign fsm_state = state;

    // Last clock of a bit: final divisor count of the 16th oversample tick.
    assign bit_done  = (div_cnt == div_last) && (os_cnt == 4'hF);
    assign frame_end = bit_done &&
                       (((state == ST_STOP1) && !stop2) || (state == ST_STOP2));

    // Parity is resolved from the head word at pop time, with the mode
    // sampled at that same edge.
    always_comb begin
        case (Tx_PARITY)
            PAR_EVEN: par_calc = ^head;
            PAR_ODD:  par_calc = ~(^head);
            default:  par_calc = 1'b1;
        endcase
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (Tx_EN && !fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (bit_done) state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (bit_done && (bit_idx == BIT_W'(DATA_W - 1)))
                    state_nxt = (par_mode == PAR_NONE) ? ST_STOP1 : ST_PARITY;
            end
            ST_PARITY: begin
                if (bit_done) state_nxt = ST_STOP1;
            end
            ST_STOP1: begin
                if (bit_done && stop2) state_nxt = ST_STOP2;
            end
            default: ;
        endcase
        // Chaining straight into the next start bit keeps frames gap-free.
        if (frame_end) begin
            if (Tx_EN && !fifo_empty) begin
                pop       = 1'b1;
                state_nxt = ST_START;
            end else begin
                state_nxt = ST_IDLE;
            end
        end
    end

    // TxD is the registered image of the state, so the line lags the state
    // by one clock while every bit still lasts exactly 16*DIV clocks.
    always_comb begin
        case (state)
            ST_START:  txd_nxt = 1'b0;
            ST_DATA:   txd_nxt = shreg[0];
            ST_PARITY: txd_nxt = par_bit;
            default:   txd_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            TxD         <= 1'b1;
            Tx_OVERFLOW <= 1'b0;
        end else begin
            state       <= state_nxt;
            TxD         <= txd_nxt;
            Tx_OVERFLOW <= Tx_WR && fifo_full;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg    <= '0;
            bit_idx  <= '0;
            par_mode <= PAR_NONE;
            stop2    <= 1'b0;
            par_bit  <= 1'b0;
            div_last <= '0;
            div_cnt  <= '0;
            os_cnt   <= '0;
        end else if (pop) begin
            shreg    <= head;
            bit_idx  <= '0;
            par_mode <= Tx_PARITY;
            stop2    <= Tx_STOP2;
            par_bit  <= par_calc;
            div_last <= DIV_W'(DIV_TAB[baud_select] - 1);
            div_cnt  <= '0;
            os_cnt   <= '0;
        end else if (state != ST_IDLE) begin
            if (div_cnt == div_last) begin
                div_cnt <= '0;
                os_cnt  <= os_cnt + 4'd1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            if (bit_done && (state == ST_DATA)) begin
                shreg   <= shreg >> 1;
                bit_idx <= bit_idx + 1'b1;
            end
        end else begin
            div_cnt <= '0;
            os_cnt  <= '0;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench for uart_tx_fifo at 50 MHz, 115200 baud
// (432 clocks per bit). Inputs change on the falling edge; outputs are
// sampled on the falling edge.
module tb_uart_tx_fifo;
    import uart_pkg::*;

    localparam int BIT_CYC = 432;

    logic        clk = 1'b0;
    logic        reset;
    logic        Tx_EN;
    logic        Tx_WR;
    logic [7:0]  Tx_DATA;
    logic [2:0]  baud_select;
    logic [1:0]  Tx_PARITY;
    logic        Tx_STOP2;
    logic        TxD;
    logic        Tx_BUSY;
    logic        Tx_FULL;
    logic        Tx_EMPTY;
    logic [4:0]  Tx_LEVEL;
    logic        Tx_OVERFLOW;
    uart_state_e fsm_state;

    int vectors     = 0;
    int miscompares = 0;

    always #10 clk = ~clk;

    uart_tx_fifo #(
        .CLK_FREQ   (50000000),
        .DATA_W     (8),
        .FIFO_DEPTH (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .Tx_EN       (Tx_EN),
        .Tx_WR       (Tx_WR),
        .Tx_DATA     (Tx_DATA),
        .baud_select (baud_select),
        .Tx_PARITY   (Tx_PARITY),
        .Tx_STOP2    (Tx_STOP2),
        .TxD         (TxD),
        .Tx_BUSY     (Tx_BUSY),
        .Tx_FULL     (Tx_FULL),
        .Tx_EMPTY    (Tx_EMPTY),
        .Tx_LEVEL    (Tx_LEVEL),
        .Tx_OVERFLOW (Tx_OVERFLOW),
        .fsm_state   (fsm_state)
    );

    // Returns at the falling edge just after the write edge.
    task automatic write_word(input logic [7:0] d);
        @(negedge clk);
        Tx_WR   = 1'b1;
        Tx_DATA = d;
        @(negedge clk);
        Tx_WR   = 1'b0;
    endtask

    task automatic wait_start(input int max_cyc, input string name);
        int n;
        n = 0;
        while (TxD !== 1'b0 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (TxD !== 1'b0) begin
            miscompares++;
            $display("FAIL %s start bit: TxD=%b after %0d cycles, expected 0", name, TxD, n);
        end
    endtask

    // Called at the first falling edge of the start bit; bits[i] is the
    // i-th bit on the line. Every cycle of every bit is compared.
    task automatic check_frame(input logic [15:0] bits, input int nbits,
                               input string name, input int drop_en_at);
        int bad;
        for (int b = 0; b < nbits; b++) begin
            bad = 0;
            for (int c = 0; c < BIT_CYC; c++) begin
                if (b != 0 || c != 0) @(negedge clk);
                if (b * BIT_CYC + c == drop_en_at) Tx_EN = 1'b0;
                if (TxD !== bits[b]) bad++;
            end
            vectors++;
            if (bad != 0) begin
                miscompares++;
                $display("FAIL %s bit %0d: TxD wrong in %0d of %0d cycles, expected %b",
                         name, b, bad, BIT_CYC, bits[b]);
            end
        end
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        Tx_EN       = 1'b0;
        Tx_WR       = 1'b0;
        Tx_DATA     = 8'h00;
        baud_select = 3'b111;
        Tx_PARITY   = 2'b00;
        Tx_STOP2    = 1'b0;
        #250;
        vectors++;
        if ({TxD, Tx_BUSY, Tx_FULL, Tx_EMPTY, Tx_LEVEL, Tx_OVERFLOW} !== {4'b1001, 5'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_during: TxD/BUSY/FULL/EMPTY/LEVEL/OVF=%b/%b/%b/%b/%0d/%b, expected 1/0/0/1/0/0",
                     TxD, Tx_BUSY, Tx_FULL, Tx_EMPTY, Tx_LEVEL, Tx_OVERFLOW);
        end
        #250;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({TxD, Tx_BUSY, Tx_EMPTY, Tx_LEVEL} !== {3'b101, 5'd0} || fsm_state !== ST_IDLE) begin
            miscompares++;
            $display("FAIL reset_after: TxD/BUSY/EMPTY/LEVEL=%b/%b/%b/%0d state=%0d, expected 1/0/1/0 state 0",
                     TxD, Tx_BUSY, Tx_EMPTY, Tx_LEVEL, fsm_state);
        end
    endtask

    task automatic test_even_parity();
        Tx_EN     = 1'b1;
        Tx_PARITY = 2'b01;
        Tx_STOP2  = 1'b0;
        write_word(8'h99);
        @(negedge clk);
        vectors++;
        if (TxD !== 1'b1 || Tx_BUSY !== 1'b1 || fsm_state !== ST_START) begin
            miscompares++;
            $display("FAIL latency_pop: TxD=%b BUSY=%b state=%0d, expected 1/1 state 1",
                     TxD, Tx_BUSY, fsm_state);
        end
        @(negedge clk);
        vectors++;
        if (TxD !== 1'b0) begin
            miscompares++;
            $display("FAIL latency_start: TxD=%b two edges after write, expected 0", TxD);
        end
        // 0x99, LSB first, even parity 0, one stop bit.
        check_frame(16'h0532, 11, "even_99", -1);
        @(negedge clk);
        vectors++;
        if (TxD !== 1'b1 || Tx_BUSY !== 1'b0) begin
            miscompares++;
            $display("FAIL even_end: TxD=%b BUSY=%b, expected 1/0", TxD, Tx_BUSY);
        end
    endtask

    task automatic test_odd_parity_stop2();
        Tx_PARITY = 2'b10;
        Tx_STOP2  = 1'b1;
        write_word(8'hAA);
        wait_start(10, "odd_aa");
        // 0xAA, LSB first, odd parity 1, two stop bits.
        check_frame(16'h0F54, 12, "odd_aa", -1);
        @(negedge clk);
        vectors++;
        if (TxD !== 1'b1 || Tx_BUSY !== 1'b0) begin
            miscompares++;
            $display("FAIL odd_end: TxD=%b BUSY=%b, expected 1/0", TxD, Tx_BUSY);
        end
    endtask

    task automatic test_fill_overflow_back_to_back();
        logic [15:0] fb;
        Tx_EN     = 1'b0;
        Tx_PARITY = 2'b00;
        Tx_STOP2  = 1'b0;
        for (int i = 0; i < 15; i++) write_word(8'(i));
        vectors++;
        if (Tx_LEVEL !== 5'd15 || Tx_FULL !== 1'b0) begin
            miscompares++;
            $display("FAIL fill_15: LEVEL=%0d FULL=%b, expected 15/0", Tx_LEVEL, Tx_FULL);
        end
        write_word(8'h0F);
        vectors++;
        if (Tx_LEVEL !== 5'd16 || Tx_FULL !== 1'b1 || Tx_EMPTY !== 1'b0 || TxD !== 1'b1) begin
            miscompares++;
            $display("FAIL fill_16: LEVEL=%0d FULL=%b EMPTY=%b TxD=%b, expected 16/1/0/1",
                     Tx_LEVEL, Tx_FULL, Tx_EMPTY, TxD);
        end
        vectors++;
        if (Tx_OVERFLOW !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_idle: OVERFLOW=%b before drop, expected 0", Tx_OVERFLOW);
        end
        write_word(8'h10);
        vectors++;
        if (Tx_OVERFLOW !== 1'b1 || Tx_LEVEL !== 5'd16) begin
            miscompares++;
            $display("FAIL ovf_pulse: OVERFLOW=%b LEVEL=%0d, expected 1/16", Tx_OVERFLOW, Tx_LEVEL);
        end
        @(negedge clk);
        vectors++;
        if (Tx_OVERFLOW !== 1'b0 || TxD !== 1'b1 || fsm_state !== ST_IDLE) begin
            miscompares++;
            $display("FAIL ovf_clear: OVERFLOW=%b TxD=%b state=%0d, expected 0/1 state 0",
                     Tx_OVERFLOW, TxD, fsm_state);
        end
        Tx_EN = 1'b1;
        wait_start(10, "b2b");
        for (int i = 0; i < 16; i++) begin
            if (i != 0) @(negedge clk);
            fb = {6'b0, 1'b1, 8'(i), 1'b0};
            check_frame(fb, 10, $sformatf("b2b_%0d", i), -1);
        end
        @(negedge clk);
        vectors++;
        if (TxD !== 1'b1 || Tx_EMPTY !== 1'b1 || Tx_BUSY !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_end: TxD=%b EMPTY=%b BUSY=%b, expected 1/1/0", TxD, Tx_EMPTY, Tx_BUSY);
        end
    endtask

    task automatic test_enable_drop();
        int lows;
        Tx_EN = 1'b0;
        write_word(8'h3C);
        write_word(8'hC3);
        write_word(8'h5A);
        write_word(8'hA5);
        Tx_EN = 1'b1;
        wait_start(10, "en_drop");
        // Tx_EN falls during data bit 3; the frame must still finish.
        check_frame({6'b0, 1'b1, 8'h3C, 1'b0}, 10, "en_drop", 2000);
        @(negedge clk);
        vectors++;
        if (TxD !== 1'b1 || Tx_LEVEL !== 5'd3 || fsm_state !== ST_IDLE || Tx_BUSY !== 1'b1) begin
            miscompares++;
            $display("FAIL en_drop_end: TxD=%b LEVEL=%0d state=%0d BUSY=%b, expected 1/3 state 0 busy 1",
                     TxD, Tx_LEVEL, fsm_state, Tx_BUSY);
        end
        lows = 0;
        repeat (500) begin
            @(negedge clk);
            if (TxD !== 1'b1) lows++;
        end
        vectors++;
        if (lows != 0 || Tx_LEVEL !== 5'd3) begin
            miscompares++;
            $display("FAIL en_drop_hold: TxD low %0d cycles LEVEL=%0d, expected 0 cycles level 3",
                     lows, Tx_LEVEL);
        end
    endtask

    task automatic test_reset_mid_frame();
        int bad;
        write_word(8'h11);
        write_word(8'h22);
        Tx_EN = 1'b1;
        wait_start(10, "rst_mid");
        // 0xC3 goes out first; its data bit 2 (line bit 3) is 0.
        repeat (3 * BIT_CYC + 100) @(negedge clk);
        vectors++;
        if (TxD !== 1'b0 || Tx_LEVEL !== 5'd4 || fsm_state !== ST_DATA) begin
            miscompares++;
            $display("FAIL rst_mid_pre: TxD=%b LEVEL=%0d state=%0d, expected 0/4 state 2",
                     TxD, Tx_LEVEL, fsm_state);
        end
        #3;
        reset = 1'b1;
        #1;
        vectors++;
        if ({TxD, Tx_BUSY, Tx_FULL, Tx_EMPTY, Tx_LEVEL} !== {4'b1001, 5'd0} || fsm_state !== ST_IDLE) begin
            miscompares++;
            $display("FAIL rst_mid_async: TxD/BUSY/FULL/EMPTY/LEVEL=%b/%b/%b/%b/%0d state=%0d, expected 1/0/0/1/0 state 0",
                     TxD, Tx_BUSY, Tx_FULL, Tx_EMPTY, Tx_LEVEL, fsm_state);
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (TxD !== 1'b1 || Tx_BUSY !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL rst_mid_after: TxD low or BUSY high in %0d cycles, expected 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_even_parity();
        test_odd_parity_stop2();
        test_fill_overflow_back_to_back();
        test_enable_drop();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised next-generation UART transmitter. It has a transmit FIFO, configurable data width, runtime parity mode and 1/2 stop bits. Host writes are buffered, and frames go out back-to-back with no idle gap. It is a drop-in successor on the TxD side of the existing UART link and is clocked at CLK_FREQ. It uses the same 8-entry baud_select table and 16x oversample tick as the existing receiver.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz; sets the baud divisor table.
DATA_W, 8, data bits per frame; legal range 5..9.
FIFO_DEPTH, 16, TX FIFO entries; power of 2, minimum 2.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
Tx_EN  in  1  transmit enable; gates frame start only.
Tx_WR  in  1  write strobe; pushes Tx_DATA when not full.
Tx_DATA  in  DATA_W  data word to queue.
baud_select  in  3  rate select: 000=300, 001=1200, 010=4800, 011=9600, 100=19200, 101=38400, 110=57600, 111=115200.
Tx_PARITY  in  2  parity mode: 00 none, 01 even, 10 odd, 11 mark (constant 1).
Tx_STOP2  in  1  0 = one stop bit, 1 = two stop bits.
TxD  out  1  serial line; idles high; registered.
Tx_BUSY  out  1  FIFO non-empty or FSM not IDLE.
Tx_FULL  out  1  FIFO level == FIFO_DEPTH.
Tx_EMPTY  out  1  FIFO level == 0.
Tx_LEVEL  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
Tx_OVERFLOW  out  1  one-cycle pulse when a write is dropped.

Behaviour:
- Reset (asynchronous, immediate):
  - TxD=1, Tx_BUSY=0, Tx_FULL=0, Tx_EMPTY=1, Tx_LEVEL=0, Tx_OVERFLOW=0.
  - FIFO pointers are cleared, FSM goes to IDLE and the baud counter is cleared.
  - A reset asserted mid-frame aborts the frame and discards all queued data.
- Baud timing:
  - Tick divisor DIV = round(CLK_FREQ/(16*baud)). At 50 MHz: 10417, 2604, 651, 326, 163, 81, 54, 27.
  - Every bit lasts exactly 16*DIV clk cycles.
  - baud_select, Tx_PARITY and Tx_STOP2 are latched when a word is popped. Changes mid-frame affect only later frames.
- FIFO:
  - Tx_WR && !Tx_FULL writes Tx_DATA at that edge.
  - Tx_WR && Tx_FULL drops the word and pulses Tx_OVERFLOW for one cycle. This holds even if a pop occurs in the same cycle; full is judged on the pre-edge level.
  - A simultaneous push and pop leaves Tx_LEVEL unchanged.
  - Order is strictly first in, first out.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
  - IDLE: TxD=1. If Tx_EN && !Tx_EMPTY, pop the head word into the shift register, clear the baud counter and go to START.
  - START: TxD=0 for one bit time, then go to DATA.
  - DATA: DATA_W bits, LSB first. Then go to PARITY if the mode is not 00, else to STOP1.
  - PARITY: even = XOR of the data bits; odd = inverse of that; mark = 1.
  - STOP1: TxD=1. Then go to STOP2 if latched Tx_STOP2=1; otherwise end the frame.
  - STOP2: TxD=1 for a second bit time, then end the frame.
  - End of frame: in the last cycle of the final stop bit, if Tx_EN && !Tx_EMPTY, pop the next word and go to START directly with zero idle cycles; else go to IDLE.
- Latency: with the FSM in IDLE and Tx_EN=1, a write sampled at edge N gives a pop at edge N+1 and TxD=0 registered at edge N+2.
- Tx_EN:
  - Deasserting Tx_EN mid-frame lets the current frame complete; no new frame starts.
  - Writes are accepted while Tx_EN=0.
- Tx_BUSY is combinational from FSM state and FIFO level. It falls in the cycle after the final stop bit ends with the FIFO empty.
- Frame length = 1 + DATA_W + (parity?1:0) + (Tx_STOP2?2:1) bit times.

Decomposition:
- Shared package uart_pkg holds:
  - the baud divisor function of (CLK_FREQ, baud_select);
  - parity mode constants PAR_NONE, PAR_EVEN, PAR_ODD, PAR_MARK;
  - the FSM state encoding.
  The receiver successor reuses this package.
- One sub-module, uart_sync_fifo: parametrised by width and depth, with push/pop/full/empty/level and a registered read head.
- Baud counter and shifter stay in the top level.

Test Plan:
1. Reset asserted for 500 ns, then released -> TxD=1, Tx_BUSY=0, Tx_EMPTY=1, Tx_LEVEL=0 during and after reset.
2. baud_select=111, Tx_PARITY=01, Tx_STOP2=0, write 8'h99 -> TxD sequence 0,1,0,0,1,1,0,0,1,0,1. Each bit is 432 clk cycles, total 4752 cycles. The start edge falls 2 edges after the write. Tx_BUSY then drops.
3. Tx_PARITY=10, Tx_STOP2=1, write 8'hAA -> 12-bit frame 0,0,1,0,1,0,1,0,1,1,1,1 (odd parity bit = 1).
4. With Tx_EN=0, write 17 words 8'h00..8'h10 -> Tx_FULL=1 at level 16. The 17th write pulses Tx_OVERFLOW for one cycle and is dropped, and TxD stays 1. Then raise Tx_EN -> 16 frames, 8'h00..8'h0F in order, with zero idle cycles between the stop bit and the next start bit.
5. Deassert Tx_EN midway through a frame with 3 words queued -> the current frame completes, TxD stays 1 afterwards and Tx_LEVEL=3.
6. Assert reset mid-data-bit of a frame with 4 words queued -> TxD=1 with no clock edge needed, Tx_LEVEL=0. After release, no frame is transmitted.
